// File: rtl/xbar_ctx_sequencer.sv
// xbar_ctx_sequencer: steps the PE input crossbar through a table of routing
// contexts (one select word per output plus a dwell count) for a programmed
// number of passes, driving cb_en_o/select_o from registers.
// Optional feature macro: XBAR_SEQ_RANGE_CHK_EN (zero out-of-range select
// fields on table writes and flag them on cfg_err).
module xbar_ctx_sequencer #(
  parameter int NUM_INPUTS  = 14,
  parameter int NUM_OUTPUTS = 16,
  parameter int NUM_CTX     = 8,
  parameter int CNT_W       = 8,
  localparam int CTX_W      = $clog2(NUM_CTX),
  localparam int SEL_W      = $clog2(NUM_INPUTS),
  localparam int SW         = NUM_OUTPUTS * SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CTX_W-1:0] cfg_addr,
  input  logic [SW-1:0]    cfg_sel,
  input  logic [CNT_W-1:0] cfg_hold,
  output logic             cfg_err,
  input  logic             start,
  input  logic [CTX_W-1:0] last_ctx_i,
  input  logic [CNT_W-1:0] loops_i,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [CTX_W-1:0] ctx_o,
  output logic             cb_en_o,
  output logic [SW-1:0]    select_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    sel_tab  [NUM_CTX];
  logic [CNT_W-1:0] hold_tab [NUM_CTX];
  logic [CTX_W-1:0] ctx_nx, ctx_inc, last, last_nx;
  logic [CNT_W-1:0] dwell, dwell_nx, loops, loops_nx;
  logic [SW-1:0]    select_nx, wr_sel;
  logic             busy_nx, done_nx, cb_en_nx, err_nx, wr_ok, wr_bad;

`ifdef XBAR_SEQ_RANGE_CHK_EN
  // Replace every select field that names a non-existent input with 0.
  function automatic logic [SW-1:0] clamp_sel(input logic [SW-1:0] w);
    logic [SW-1:0] r;
    r = w;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (int'(w[i*SEL_W +: SEL_W]) >= NUM_INPUTS) begin
        r[i*SEL_W +: SEL_W] = '0;
      end else begin
        r[i*SEL_W +: SEL_W] = w[i*SEL_W +: SEL_W];
      end
    end
    return r;
  endfunction

  // True when any select field names a non-existent input.
  function automatic logic sel_bad(input logic [SW-1:0] w);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (int'(w[i*SEL_W +: SEL_W]) >= NUM_INPUTS) begin
        b = 1'b1;
      end else begin
        b = b;
      end
    end
    return b;
  endfunction
`endif

  // Table write acceptance, write-data conditioning and error detection.
  always_comb begin
    wr_ok = cfg_we && (state != RUN);
`ifdef XBAR_SEQ_RANGE_CHK_EN
    wr_sel = clamp_sel(cfg_sel);
    wr_bad = sel_bad(cfg_sel);
`else
    wr_sel = cfg_sel;
    wr_bad = 1'b0;
`endif
    err_nx = (cfg_we && (state == RUN)) || (wr_ok && wr_bad);
  end

  // Context table storage; cleared on reset, writable outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        sel_tab[i]  <= '0;
        hold_tab[i] <= '0;
      end
    end else if (wr_ok) begin
      sel_tab[cfg_addr]  <= wr_sel;
      hold_tab[cfg_addr] <= cfg_hold;
    end
  end

  assign ctx_inc = ctx_o + CTX_W'(1);

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    state_nx  = state;
    ctx_nx    = ctx_o;
    last_nx   = last;
    dwell_nx  = dwell;
    loops_nx  = loops;
    select_nx = select_o;
    busy_nx   = 1'b0;
    done_nx   = 1'b0;
    cb_en_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          last_nx   = last_ctx_i;
          loops_nx  = loops_i;
          ctx_nx    = '0;
          dwell_nx  = hold_tab[CTX_W'(0)];
          select_nx = sel_tab[CTX_W'(0)];
          busy_nx   = 1'b1;
          cb_en_nx  = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        busy_nx  = 1'b1;
        cb_en_nx = 1'b1;
        if (stop) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          cb_en_nx = 1'b0;
          done_nx  = 1'b1;
        end else if (dwell != '0) begin
          dwell_nx = dwell - CNT_W'(1);
        end else if (ctx_o < last) begin
          ctx_nx    = ctx_inc;
          dwell_nx  = hold_tab[ctx_inc];
          select_nx = sel_tab[ctx_inc];
        end else if (loops != '0) begin
          loops_nx  = loops - CNT_W'(1);
          ctx_nx    = '0;
          dwell_nx  = hold_tab[CTX_W'(0)];
          select_nx = sel_tab[CTX_W'(0)];
        end else begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          cb_en_nx = 1'b0;
          done_nx  = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ctx_o    <= '0;
      last     <= '0;
      dwell    <= '0;
      loops    <= '0;
      select_o <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cb_en_o  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      ctx_o    <= ctx_nx;
      last     <= last_nx;
      dwell    <= dwell_nx;
      loops    <= loops_nx;
      select_o <= select_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      cb_en_o  <= cb_en_nx;
      cfg_err  <= err_nx;
    end
  end

endmodule
